// File: rtl/regfile_sb.sv
// regfile_sb
//   Parametrised register file with a scoreboard. It sits between decode and
//   writeback. It has one synchronous write port and two combinational read
//   ports (S and T), and each read port has an optional same-cycle write
//   bypass. It also holds a conditional-bit (CB) flag and one busy bit per
//   register, which track in-flight producers so that decode can stall.
//
//   Parameters
//     DATA_W   register width
//     ADDR_W   address width, DEPTH = 2**ADDR_W
//     ZERO_REG 1: r0 reads as zero, ignores writes, never becomes busy
//     BYPASS   1: the current-cycle write / CB write is forwarded to outputs
//
//   Ports
//     clk_i, rst_i                 clock, async active-high reset
//     write_i/_addr_i/_data_i      register write port (writeback)
//     write_CB_i, cb_data_i        CB write port
//     cb_data_o                    CB value
//     rs_addr_i/rs_data_o          read port S
//     rt_addr_i/rt_data_o          read port T
//     reserve_i, reserve_addr_i    mark a register busy (decode issue)
//     rs_busy_o, rt_busy_o         operand of S / T still pending
//     busy_count_o                 number of busy registers

// ---------------------------------------------------------------------------
// One register entry. It holds the data word and the busy bit.
// ---------------------------------------------------------------------------
module regfile_sb_entry #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr,      // write hits this entry (already qualified)
  input  logic [DATA_W-1:0] wdata,
  input  logic              res,     // reserve hits this entry (already qualified)
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   data <= '0;
    else if (wr) data <= wdata;
  end

  // A reserve on the same edge as a write means a newer producer has been
  // issued. The register must therefore stay busy, so reserve wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     busy <= 1'b0;
    else if (res)  busy <= 1'b1;
    else if (wr)   busy <= 1'b0;
  end

endmodule

// ---------------------------------------------------------------------------
// One read port. It selects the stored data and busy bit, and it forwards
// the current-cycle write when BYPASS is set.
// ---------------------------------------------------------------------------
module regfile_sb_rdport #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   regs,
  input  logic [(1<<ADDR_W)-1:0]               busy_vec,
  input  logic                                 write,
  input  logic [ADDR_W-1:0]                    waddr,
  input  logic [DATA_W-1:0]                    wdata,
  output logic [DATA_W-1:0]                    data,
  output logic                                 busy
);

  logic is_zero;
  logic fwd;

  assign is_zero = (ZERO_REG != 0) && (addr == '0);
  assign fwd     = (BYPASS != 0) && write && (waddr == addr);

  always_comb begin
    data = regs[addr];
    busy = busy_vec[addr];
    if (fwd) begin
      // The value is arriving this cycle, so the operand is not pending.
      data = wdata;
      busy = 1'b0;
    end
    if (is_zero) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic              write_CB_i,
  input  logic              cb_data_i,
  output logic              cb_data_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic              reserve_i,
  input  logic [ADDR_W-1:0] reserve_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic [ADDR_W:0]   busy_count_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int NPORT = 2;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             wr_hit;
  logic [DEPTH-1:0]             res_hit;

  // Reserves of r0 are dropped when r0 is hard-wired, so the count never
  // includes r0.
  logic res_eff;
  assign res_eff = reserve_i && !((ZERO_REG != 0) && (reserve_addr_i == '0));

  // -------------------------------------------------------------------------
  // Register entries
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic is_r0_fixed;
    assign is_r0_fixed = (ZERO_REG != 0) && (i == 0);
    assign wr_hit[i]   = write_i && (write_addr_i == ADDR_W'(i)) && !is_r0_fixed;
    assign res_hit[i]  = res_eff && (reserve_addr_i == ADDR_W'(i));

    regfile_sb_entry #(.DATA_W(DATA_W)) u_ent (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wr    (wr_hit[i]),
      .wdata (write_data_i),
      .res   (res_hit[i]),
      .data  (regs[i]),
      .busy  (busy[i])
    );
  end

  // -------------------------------------------------------------------------
  // Read ports: index 0 = S, 1 = T
  // -------------------------------------------------------------------------
  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;
  logic [NPORT-1:0]             rd_busy;

  assign rd_addr[0] = rs_addr_i;
  assign rd_addr[1] = rt_addr_i;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .addr     (rd_addr[p]),
      .regs     (regs),
      .busy_vec (busy),
      .write    (write_i),
      .waddr    (write_addr_i),
      .wdata    (write_data_i),
      .data     (rd_data[p]),
      .busy     (rd_busy[p])
    );
  end

  assign rs_data_o = rd_data[0];
  assign rt_data_o = rd_data[1];
  assign rs_busy_o = rd_busy[0];
  assign rt_busy_o = rd_busy[1];

  // -------------------------------------------------------------------------
  // CB flag
  // -------------------------------------------------------------------------
  logic cb;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           cb <= 1'b0;
    else if (write_CB_i) cb <= cb_data_i;
  end

  assign cb_data_o = ((BYPASS != 0) && write_CB_i) ? cb_data_i : cb;

  // -------------------------------------------------------------------------
  // Busy count, maintained incrementally.
  //   inc: a reserve sets a bit that is currently clear.
  //   dec: a write clears a set bit, unless a reserve to the same address
  //        keeps that bit set.
  // For the same address, the reserve case gives +1 when the bit was clear
  // and 0 when it was already busy. r0 cannot become busy when it is
  // hard-wired, so a write to r0 cannot decrement the count.
  // -------------------------------------------------------------------------
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] cnt;

  assign inc = res_eff && !busy[reserve_addr_i];
  assign dec = write_i && busy[write_addr_i] &&
               !(res_eff && (reserve_addr_i == write_addr_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else       cnt <= cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
  end

  assign busy_count_o = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   The bench drives two regfile_sb instances with the same inputs:
//     cfg0: ZERO_REG=0, BYPASS=1 (defaults)
//     cfg1: ZERO_REG=1, BYPASS=0
//   It first applies directed steps, then random traffic with occasional
//   asynchronous reset pulses. Each output is compared against an
//   array-based reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       write, wcb, cbin, res;
  logic [2:0] waddr, rsa, rta, resa;
  logic [7:0] wdata;

  logic [7:0] rs_d [2];
  logic [7:0] rt_d [2];
  logic       cb_o [2];
  logic       rsb  [2];
  logic       rtb  [2];
  logic [3:0] cnt  [2];

  int vectors    = 0;
  int miscompares = 0;

  regfile_sb dut0 (
    .clk_i(clk), .rst_i(rst),
    .write_i(write), .write_addr_i(waddr), .write_data_i(wdata),
    .write_CB_i(wcb), .cb_data_i(cbin), .cb_data_o(cb_o[0]),
    .rs_addr_i(rsa), .rs_data_o(rs_d[0]), .rt_addr_i(rta), .rt_data_o(rt_d[0]),
    .reserve_i(res), .reserve_addr_i(resa),
    .rs_busy_o(rsb[0]), .rt_busy_o(rtb[0]), .busy_count_o(cnt[0])
  );

  regfile_sb #(.ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .write_i(write), .write_addr_i(waddr), .write_data_i(wdata),
    .write_CB_i(wcb), .cb_data_i(cbin), .cb_data_o(cb_o[1]),
    .rs_addr_i(rsa), .rs_data_o(rs_d[1]), .rt_addr_i(rta), .rt_data_o(rt_d[1]),
    .reserve_i(res), .reserve_addr_i(resa),
    .rs_busy_o(rsb[1]), .rt_busy_o(rtb[1]), .busy_count_o(cnt[1])
  );

  // ---------------- reference model ----------------
  logic [7:0] m_reg  [2][8];
  bit         m_busy [2][8];
  bit         m_cb   [2];

  function automatic bit zr(int c); return c == 1; endfunction
  function automatic bit by(int c); return c == 0; endfunction

  function automatic logic [7:0] exp_rd(int c, logic [2:0] a);
    if (zr(c) && a == 0) return 8'h00;
    if (by(c) && write && waddr == a) return wdata;
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [2:0] a);
    if (zr(c) && a == 0) return 1'b0;
    if (by(c) && write && waddr == a) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic exp_cb(int c);
    if (by(c) && wcb) return cbin;
    return m_cb[c];
  endfunction

  function automatic logic [3:0] exp_cnt(int c);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_busy[c][i]);
    return 4'(n);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cb[c] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_reg[c][i]  = 8'h00;
        m_busy[c][i] = 1'b0;
      end
    end
  endtask

  // State after a rising edge. A write retires its producer, and a reserve
  // then issues a new one. Applying them in that order means reserve wins.
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (write) begin
        if (!(zr(c) && waddr == 0)) m_reg[c][waddr] = wdata;
        m_busy[c][waddr] = 1'b0;
      end
      if (res && !(zr(c) && resa == 0)) m_busy[c][resa] = 1'b1;
      if (wcb) m_cb[c] = cbin;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cfg%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk("rs_data", c, 32'(rs_d[c]), 32'(exp_rd(c, rsa)));
      chk("rt_data", c, 32'(rt_d[c]), 32'(exp_rd(c, rta)));
      chk("rs_busy", c, 32'(rsb[c]),  32'(exp_busy(c, rsa)));
      chk("rt_busy", c, 32'(rtb[c]),  32'(exp_busy(c, rta)));
      chk("cb",      c, 32'(cb_o[c]), 32'(exp_cb(c)));
      chk("count",   c, 32'(cnt[c]),  32'(exp_cnt(c)));
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] s, input logic [2:0] t,
                       input logic r, input logic [2:0] ra,
                       input logic wc, input logic cv);
    write = w; waddr = wa; wdata = wd; rsa = s; rta = t;
    res = r; resa = ra; wcb = wc; cbin = cv;
  endtask

  // This task is called just after a negedge. It checks, crosses the rising
  // edge, updates the model, and returns at the next negedge.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // ---- reset mid-cycle clears state with no edge ----
    drive(1, 3, 8'h5A, 3, 3, 1, 1, 1, 1);
    tick();
    drive(0, 0, 0, 3, 1, 0, 0, 0, 0);
    #1 chk("pre_rst_r3", 0, 32'(rs_d[0]), 32'h5A);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_r3", 0, 32'(rs_d[0]), 32'h00);
    chk("rst_cb", 0, 32'(cb_o[0]), 32'h0);
    chk("rst_cnt", 0, 32'(cnt[0]), 32'h0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // ---- write/read with bypass ----
    drive(1, 2, 8'hA5, 2, 2, 0, 0, 0, 0);
    #1;
    chk("byp_rs", 0, 32'(rs_d[0]), 32'hA5);
    chk("byp_rt", 0, 32'(rt_d[0]), 32'hA5);
    chk("nobyp_rs", 1, 32'(rs_d[1]), 32'h00);
    tick();
    drive(0, 0, 0, 2, 2, 0, 0, 0, 0);
    #1;
    chk("held_rs", 0, 32'(rs_d[0]), 32'hA5);
    chk("stored_rt", 1, 32'(rt_d[1]), 32'hA5);
    tick();

    // ---- ZERO_REG ----
    drive(1, 0, 8'hFF, 0, 0, 1, 0, 0, 0);
    #1;
    chk("zr_rs_pre", 1, 32'(rs_d[1]), 32'h00);
    chk("zr_busy_pre", 1, 32'(rsb[1]), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("zr_rs_post", 1, 32'(rs_d[1]), 32'h00);
    chk("zr_busy_post", 1, 32'(rsb[1]), 32'h0);
    chk("zr_cnt", 1, 32'(cnt[1]), 32'h0);
    tick();
    do_reset();

    // ---- scoreboard ----
    drive(0, 0, 0, 5, 5, 1, 5, 0, 0);
    tick();
    drive(1, 5, 8'h11, 5, 6, 1, 6, 0, 0);
    #1;
    chk("sb_rsb_byp", 0, 32'(rsb[0]), 32'h0);
    chk("sb_rsb_nobyp", 1, 32'(rsb[1]), 32'h1);
    chk("sb_cnt1", 0, 32'(cnt[0]), 32'h1);
    tick();
    drive(0, 0, 0, 6, 5, 0, 0, 0, 0);
    #1;
    chk("sb_r6_busy", 0, 32'(rsb[0]), 32'h1);
    chk("sb_cnt_after", 0, 32'(cnt[0]), 32'h1);
    chk("sb_r5_data", 1, 32'(rt_d[1]), 32'h11);
    tick();

    // ---- same-address reserve + write ----
    drive(1, 4, 8'h22, 4, 4, 1, 4, 0, 0);
    tick();
    drive(0, 0, 0, 4, 4, 0, 0, 0, 0);
    #1;
    chk("same_data", 0, 32'(rs_d[0]), 32'h22);
    chk("same_busy", 0, 32'(rsb[0]), 32'h1);
    chk("same_cnt_inc", 0, 32'(cnt[0]), 32'h2);
    tick();
    drive(1, 4, 8'h33, 4, 4, 1, 4, 0, 0);
    tick();
    drive(0, 0, 0, 4, 4, 0, 0, 0, 0);
    #1;
    chk("same_cnt_keep", 0, 32'(cnt[0]), 32'h2);
    chk("same_data2", 1, 32'(rs_d[1]), 32'h33);
    tick();

    // ---- CB ----
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("cb_byp", 0, 32'(cb_o[0]), 32'h1);
    chk("cb_nobyp", 1, 32'(cb_o[1]), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("cb_hold0", 0, 32'(cb_o[0]), 32'h1);
    chk("cb_hold1", 1, 32'(cb_o[1]), 32'h1);
    tick();

    // ---- random traffic ----
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, clocked successor to the processor's 8×8 register file: synchronous write port, two combinational read ports with optional same-cycle write bypass, a conditional-bit (CB) flag register, and a per-register busy scoreboard for in-flight producers. Sits between decode (read ports, reserve) and writeback (write port, CB write). Decode uses `rs_busy_o` and `rt_busy_o` to stall.

## Interface
- `DATA_W`, default 8: register width in bits.
- `ADDR_W`, default 3: address width; DEPTH = 2^ADDR_W registers.
- `ZERO_REG`, default 0: if 1, register 0 is hard-wired to zero and is never busy.
- `BYPASS`, default 1: if 1, a write in the current cycle is forwarded to the read ports and to `cb_data_o`.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `write_i` in 1: register write enable.
- `write_addr_i` in ADDR_W: write address.
- `write_data_i` in DATA_W: write data.
- `write_CB_i` in 1: CB write enable.
- `cb_data_i` in 1: CB write value.
- `cb_data_o` out 1: CB value.
- `rs_addr_i` in ADDR_W: read port S address.
- `rs_data_o` out DATA_W: read port S data.
- `rt_addr_i` in ADDR_W: read port T address.
- `rt_data_o` out DATA_W: read port T data.
- `reserve_i` in 1: mark `reserve_addr_i` busy (producer issued).
- `reserve_addr_i` in ADDR_W: register to reserve.
- `rs_busy_o` out 1: S operand not yet available.
- `rt_busy_o` out 1: T operand not yet available.
- `busy_count_o` out ADDR_W+1: number of busy registers.

## Operation
- **Reset.** While `rst_i`=1, all registers, CB and busy bits clear immediately, independent of the clock. Outputs then show data 0, `cb_data_o`=0, busy 0, `busy_count_o`=0.
- **Write.** On a rising edge with `write_i`=1, `write_data_i` is stored to `write_addr_i`. If ZERO_REG=1 and the address is 0, the write is discarded.
- **Read.** Reads are combinational from stored state.
  - BYPASS=1: if `write_i`=1 and `write_addr_i` equals the read address, the port returns `write_data_i` in the same cycle. Exception: ZERO_REG=1 with address 0 always returns 0.
  - BYPASS=0: the port returns stored state only; the written value appears the cycle after the edge.
- **CB.** On a rising edge with `write_CB_i`=1, CB takes `cb_data_i`. With BYPASS=1, `cb_data_o` = `cb_data_i` while `write_CB_i`=1.
- **Scoreboard.** There is one busy bit per register.
  - `reserve_i` sets the bit for `reserve_addr_i` on the edge. Reserving a register that is already busy leaves it busy.
  - `write_i` clears the bit for `write_addr_i` on the edge.
  - Simultaneous reserve and write to the same address: the bit is 1 after the edge (reserve wins, since the newer producer is still pending). The data write still occurs.
  - ZERO_REG=1: reserves of address 0 are ignored.
  - Writes to non-busy registers are legal and leave the bit at 0.
- **Busy outputs.**
  - `rs_busy_o` = busy[rs_addr_i], forced to 0 when BYPASS=1 and a same-cycle write matches `rs_addr_i`. Same rule for `rt_busy_o`.
  - `busy_count_o` is a registered popcount that always equals the number of set busy bits after each edge. It is maintained incrementally: +1 for a reserve that sets a clear bit, −1 for a write that clears a set bit, net 0 when both occur on different addresses.

## Timing
- Write-to-stored latency is 1 edge.
- Bypass path is combinational: write input to read output in 0 cycles.
- Reserve-to-busy is 1 edge. Write-to-not-busy is 0 cycles with BYPASS=1 and 1 edge with BYPASS=0.
- `busy_count_o` updates on the same edge as the busy bits.
- Reset assertion is asynchronous. Deassertion is expected to be synchronised externally. The first write is accepted on the first edge after deassertion.

## Test plan
- **Reset.** Defaults; write 0x5A to r3, then assert `rst_i` mid-cycle -> `rs_data_o`(r3)=0x00, `cb_data_o`=0, `busy_count_o`=0, all without a clock edge.
- **Write/read with bypass.** BYPASS=1: write 0xA5 to r2 with `rs_addr_i`=2 and `rt_addr_i`=2 -> both outputs are 0xA5 in the same cycle and remain 0xA5 after the edge with `write_i`=0. BYPASS=0 -> 0x00 before the edge, 0xA5 after.
- **ZERO_REG.** ZERO_REG=1: write 0xFF to r0 and reserve r0 -> `rs_data_o`=0 and `rs_busy_o`=0 both before and after the edge; `busy_count_o` stays 0.
- **Scoreboard.** Reserve r5 -> `rs_busy_o`=1, `busy_count_o`=1. Next cycle write r5=0x11 while reserving r6 -> BYPASS=1 gives `rs_busy_o`=0 in that cycle; after the edge `busy_count_o`=1 and r6 is busy.
- **Simultaneous same-address.** Reserve r4 and write r4=0x22 on the same edge -> r4=0x22, busy[r4]=1, count increments by 1 if r4 was previously clear and is unchanged if it was previously busy.
- **CB.** Write CB=1 -> `cb_data_o`=1 in the same cycle (BYPASS=1) and held afterwards. Then `write_CB_i`=0 with `cb_data_i`=0 -> `cb_data_o` stays 1.
